ddr_tx_word_serializer: RTL

Parametrised HDR-DDR transmit serializer for the I3C controller's normal-transaction path. It replaces the fixed 8-bit tx path and generalises it to an arbitrary data length. It fetches payload bytes from the register file, packs byte pairs into 20-bit DDR data words (preamble, 16 data bits, 2 parity bits), and appends the CRC word. It shifts one bit per SCL edge, driven by the SCL generator's edge strobe, and sits between the register file, the frame-length logic and the SDA handler.

---
 rtl/ddr_tx_word_serializer_pkg.sv | 41 ++++
 rtl/ddr_tx_word_serializer_if.sv | 21 ++
 rtl/ddr_tx_word_serializer_crc.sv | 23 ++
 rtl/ddr_tx_word_serializer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_tx_word_serializer_pkg.sv
// Shared types, framing constants and word-build helpers for the HDR-DDR
// transmit word serializer.
package ddr_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT_DATA,
        ST_SHIFT_CRC,
        ST_DONE
    } state_t;

    localparam logic [1:0] DATA_PREAMBLE = 2'b11;
    localparam logic [1:0] CRC_PREAMBLE  = 2'b01;
    localparam logic [3:0] CRC_TOKEN     = 4'hC;
    localparam logic [4:0] CRC5_INIT     = 5'b11111;
    // x^5 + x^2 + 1, with the x^5 term implied by the shift-out
    localparam logic [4:0] CRC5_POLY     = 5'b00101;

    localparam int WORD_BITS     = 20;
    localparam int CRC_WORD_BITS = 11;

    // {PA1, PA0}: PA1 covers the odd data bits, PA0 the even bits inverted
    function automatic logic [1:0] ddr_parity(input logic [15:0] d);
        logic pa1;
        logic pa0;
        pa1 = 1'b0;
        pa0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pa1 = pa1 ^ d[2*k+1];
            pa0 = pa0 ^ d[2*k];
        end
        return {pa1, pa0};
    endfunction

    // Full 20-bit data word, MSB is the first bit on the wire
    function automatic logic [19:0] ddr_data_word(input logic [15:0] d);
        return {DATA_PREAMBLE, d, ddr_parity(d)};
    endfunction

endpackage

// File: rtl/ddr_tx_word_serializer_if.sv
// Register-file read bus between the serializer (master) and the register
// file (slave). Read data is valid one cycle after the read strobe.
interface ddr_tx_word_serializer_if #(
    parameter int ADDR_W = 10
);
    logic              o_regf_rd_en;
    logic [ADDR_W-1:0] o_regf_addr;
    logic [7:0]        i_regf_data;

    modport master (
        output o_regf_rd_en,
        output o_regf_addr,
        input  i_regf_data
    );

    modport slave (
        input  o_regf_rd_en,
        input  o_regf_addr,
        output i_regf_data
    );
endinterface

// File: rtl/ddr_tx_word_serializer_crc.sv
// One-byte CRC5 step, MSB of the byte first.
module ddr_crc5_byte
    import ddr_tx_pkg::*;
(
    input  logic [4:0] crc_in,
    input  logic [7:0] byte_in,
    output logic [4:0] crc_out
);

    // Eight serial LFSR steps unrolled into one combinational update
    always_comb begin
        logic [4:0] c;
        logic       fb;
        c  = crc_in;
        fb = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            fb = c[4] ^ byte_in[k];
            c  = {c[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
        end
        crc_out = c;
    end

endmodule

// File: rtl/ddr_tx_word_serializer.sv
// HDR-DDR transmit serializer: fetches payload byte pairs from the register
// file, frames them as 20-bit DDR data words, appends the CRC word and
// shifts one bit per SCL edge strobe.
module ddr_tx_word_serializer
    import ddr_tx_pkg::*;
#(
    parameter int         LEN_W    = 16,
    parameter int         ADDR_W   = 10,
    parameter bit         CRC_EN   = 1'b1,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic                i_sys_clk,
    input  logic                i_sys_rst,
    input  logic                i_start,
    input  logic [LEN_W-1:0]    i_data_len,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic                i_scl_edge,
    input  logic                i_abort,
    ddr_tx_word_serializer_if.master regf,
    output logic                o_sda,
    output logic                o_sda_oe,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_len_err
);

    // Fetch engine phases: 0 idle, 1 first read, 2 capture high byte and
    // optional second read, 3 capture low byte and load the shifter.
    localparam logic [1:0] FPH_IDLE = 2'd0;
    localparam logic [1:0] FPH_RD0  = 2'd1;
    localparam logic [1:0] FPH_RD1  = 2'd2;
    localparam logic [1:0] FPH_LOAD = 2'd3;

    state_t            state_q,  state_d;
    logic [1:0]        fph_q,    fph_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [LEN_W-1:0]  rem_q,    rem_d;
    logic [7:0]        hi_q,     hi_d;
    logic              lo_rd_q,  lo_rd_d;
    logic [4:0]        crc_q,    crc_d;
    logic [19:0]       sh_q,     sh_d;
    logic [4:0]        bcnt_q,   bcnt_d;
    logic              sda_q,    sda_d;
    logic              oe_q,     oe_d;
    logic              done_q,   done_d;
    logic              lerr_q,   lerr_d;

    logic [7:0]        lo_byte;
    logic [7:0]        crc_byte;
    logic [4:0]        crc_step;

    // Low byte comes from the second read, or is padding for an odd tail
    assign lo_byte  = lo_rd_q ? regf.i_regf_data : PAD_BYTE;
    // The single CRC step sees the high byte in phase 2, the low byte in phase 3
    assign crc_byte = (fph_q == FPH_RD1) ? regf.i_regf_data : lo_byte;

    ddr_crc5_byte u_crc (
        .crc_in  (crc_q),
        .byte_in (crc_byte),
        .crc_out (crc_step)
    );

    assign regf.o_regf_rd_en = (fph_q == FPH_RD0) ||
                               ((fph_q == FPH_RD1) && (rem_q != '0));
    assign regf.o_regf_addr  = addr_q;
    assign o_sda             = sda_q;
    assign o_sda_oe          = oe_q;
    assign o_busy            = (state_q != ST_IDLE);
    assign o_done            = done_q;
    assign o_len_err         = lerr_q;

    // Next-state, fetch sequencing and bit emission
    always_comb begin
        state_d = state_q;
        fph_d   = fph_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        hi_d    = hi_q;
        lo_rd_d = lo_rd_q;
        crc_d   = crc_q;
        sh_d    = sh_q;
        bcnt_d  = bcnt_q;
        sda_d   = sda_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        lerr_d  = 1'b0;

        if ((state_q != ST_IDLE) && i_abort) begin
            // Abort wins over a coincident edge; in-flight read data is dropped
            state_d = ST_IDLE;
            fph_d   = FPH_IDLE;
            rem_d   = '0;
            bcnt_d  = '0;
            sda_d   = 1'b0;
            oe_d    = 1'b0;
            crc_d   = CRC5_INIT;
        end else begin
            case (fph_q)
                FPH_RD0: begin
                    addr_d = addr_q + ADDR_W'(1);
                    rem_d  = rem_q - LEN_W'(1);
                    fph_d  = FPH_RD1;
                end
                FPH_RD1: begin
                    hi_d  = regf.i_regf_data;
                    crc_d = crc_step;
                    if (rem_q != '0) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        rem_d   = rem_q - LEN_W'(1);
                        lo_rd_d = 1'b1;
                    end else begin
                        lo_rd_d = 1'b0;
                    end
                    fph_d = FPH_LOAD;
                end
                FPH_LOAD: begin
                    crc_d  = crc_step;
                    sh_d   = ddr_data_word({hi_q, lo_byte});
                    bcnt_d = '0;
                    fph_d  = FPH_IDLE;
                    if (state_q == ST_FETCH) begin
                        state_d = ST_SHIFT_DATA;
                    end
                end
                default: ;
            endcase

            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_data_len == '0) begin
                            lerr_d = 1'b1;
                        end else begin
                            rem_d   = i_data_len;
                            addr_d  = i_base_addr;
                            crc_d   = CRC5_INIT;
                            fph_d   = FPH_RD0;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_SHIFT_DATA: begin
                    if (i_scl_edge) begin
                        sda_d  = sh_q[19];
                        sh_d   = {sh_q[18:0], 1'b0};
                        oe_d   = 1'b1;
                        bcnt_d = bcnt_q + 5'd1;
                        if (bcnt_q == 5'(WORD_BITS - 1)) begin
                            // Last bit of this word: prefetch the next one now
                            bcnt_d = '0;
                            if (rem_q != '0) begin
                                fph_d = FPH_RD0;
                            end else if (CRC_EN) begin
                                sh_d    = {CRC_PREAMBLE, CRC_TOKEN, crc_q, 9'b0};
                                state_d = ST_SHIFT_CRC;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                ST_SHIFT_CRC: begin
                    if (i_scl_edge) begin
                        sda_d  = sh_q[19];
                        sh_d   = {sh_q[18:0], 1'b0};
                        bcnt_d = bcnt_q + 5'd1;
                        if (bcnt_q == 5'(CRC_WORD_BITS - 1)) begin
                            bcnt_d  = '0;
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Hold edge: release SDA and finish the frame
                    if (i_scl_edge) begin
                        sda_d   = 1'b0;
                        oe_d    = 1'b0;
                        done_d  = 1'b1;
                        crc_d   = CRC5_INIT;
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state_q <= ST_IDLE;
            fph_q   <= FPH_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            hi_q    <= '0;
            lo_rd_q <= 1'b0;
            crc_q   <= CRC5_INIT;
            sh_q    <= '0;
            bcnt_q  <= '0;
            sda_q   <= 1'b0;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
            lerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fph_q   <= fph_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            hi_q    <= hi_d;
            lo_rd_q <= lo_rd_d;
            crc_q   <= crc_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            sda_q   <= sda_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
            lerr_q  <= lerr_d;
        end
    end

endmodule
